// File: rtl/sobel_line_feeder.sv
// Raster-to-column front end for the 3x3 Sobel window: two line buffers turn a pixel stream into (bottom, centre, top) tuples.
// Optional macro SOBEL_FEEDER_REPLICATE_EN: replicate edge rows instead of zero-padding the top and bottom borders.
module sobel_line_feeder #(
    parameter int ROWS = 512,
    parameter int COLS = 512,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pix_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic [DW-1:0] d0_o,
    output logic [DW-1:0] d1_o,
    output logic [DW-1:0] d2_o,
    output logic          done_o,
    output logic          frame_done_o
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

    state_t           state, state_next;
    logic [COL_W-1:0] in_col, drain_col, rd_addr;
    logic [ROW_W-1:0] in_row;
    logic [DW-1:0]    lb_c [COLS];
    logic [DW-1:0]    lb_t [COLS];
    logic [DW-1:0]    rd_c, rd_t, top_pad, bot_pad;
    logic             accept;

    assign ready_o = (state != DRAIN);
    assign accept  = valid_i && ready_o;
    assign rd_addr = (state == DRAIN) ? drain_col : in_col;

    // NOTE: combinational reads against registered writes give read-before-write, so a same-address write never leaks into this cycle's tuple.
    assign rd_c = lb_c[rd_addr];
    assign rd_t = lb_t[rd_addr];

`ifdef SOBEL_FEEDER_REPLICATE_EN
    assign top_pad = rd_c;
    assign bot_pad = rd_c;
`else
    assign top_pad = '0;
    assign bot_pad = '0;
`endif

    // NOTE: next-state is defaulted first so every path assigns it and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (accept && in_col == LAST_COL) state_next = RUN;
            RUN:     if (accept && in_col == LAST_COL && in_row == LAST_ROW) state_next = DRAIN;
            DRAIN:   if (drain_col == LAST_COL) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_col    <= '0;
            in_row    <= '0;
            drain_col <= '0;
        end else begin
            if (accept) begin
                if (in_col == LAST_COL) begin
                    in_col <= '0;
                    in_row <= (in_row == LAST_ROW) ? '0 : in_row + ROW_W'(1);
                end else begin
                    in_col <= in_col + COL_W'(1);
                end
            end
            if (state == DRAIN)
                drain_col <= (drain_col == LAST_COL) ? '0 : drain_col + COL_W'(1);
        end
    end

    // NOTE: line memories carry no reset; row 0 of every frame overwrites them before they are read.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_t[in_col] <= rd_c;
            lb_c[in_col] <= pix_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d0_o         <= '0;
            d1_o         <= '0;
            d2_o         <= '0;
            done_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            done_o       <= 1'b0;
            frame_done_o <= 1'b0;
            if (state == RUN && accept) begin
                d0_o   <= pix_i;
                d1_o   <= rd_c;
                d2_o   <= (in_row == ROW_W'(1)) ? top_pad : rd_t;
                done_o <= 1'b1;
            end else if (state == DRAIN) begin
                d0_o         <= bot_pad;
                d1_o         <= rd_c;
                d2_o         <= (ROWS == 2) ? '0 : rd_t;
                done_o       <= 1'b1;
                frame_done_o <= (drain_col == LAST_COL);
            end
        end
    end

endmodule
